// File: rtl/sysid_boot_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sysid_boot_checker                                                       |
// | Reads sysid words 0 (ID) and 1 (timestamp), compares them to build-time   |
// | values and reports match / mismatch / timeout.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1400042862,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout_err
);

  localparam logic [15:0] C_TMO = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_ID  = 3'd1,
    S_WAIT_ID = 3'd2,
    S_REQ_TS  = 3'd3,
    S_WAIT_TS = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic        id_ok_q, id_ok_d;
  logic        timeout_err_q, timeout_err_d;
  logic        tmo_done_q, tmo_done_d;
  logic        auto_q;

  logic w_req, w_wait, w_busy, w_accept, w_data, w_expire;

  assign w_req    = (state_q == S_REQ_ID) || (state_q == S_REQ_TS);
  assign w_wait   = (state_q == S_WAIT_ID) || (state_q == S_WAIT_TS);
  assign w_busy   = w_req || w_wait;
  assign w_accept = w_req && !avm_waitrequest;
  assign w_data   = avm_readdatavalid && (w_accept || w_wait);
  // Data arriving on the last allowed cycle wins over the timeout.
  assign w_expire = w_busy && !w_data && (cnt_q == C_TMO);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    ts_d          = ts_q;
    id_ok_d       = id_ok_q;
    timeout_err_d = timeout_err_q;
    tmo_done_d    = 1'b0;
    if (w_busy) cnt_d = cnt_q + 16'd1;
    if (w_expire) begin
      state_d       = S_IDLE;
      tmo_done_d    = 1'b1;
      timeout_err_d = 1'b1;
      id_ok_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A timeout done pulse occurs in IDLE; a start in that cycle is dropped.
          if ((start && !tmo_done_q) || auto_q) begin
            state_d = S_REQ_ID;
            cnt_d   = '0;
          end
        end
        S_REQ_ID, S_WAIT_ID: begin
          if (w_data) begin
            id_d    = avm_readdata;
            state_d = S_REQ_TS;
            cnt_d   = '0;
          end else if (w_accept) begin
            state_d = S_WAIT_ID;
          end
        end
        S_REQ_TS, S_WAIT_TS: begin
          if (w_data) begin
            ts_d    = avm_readdata;
            state_d = S_FIN;
          end else if (w_accept) begin
            state_d = S_WAIT_TS;
          end
        end
        S_FIN: begin
          id_ok_d       = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
          timeout_err_d = 1'b0;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      id_q          <= '0;
      ts_q          <= '0;
      id_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_done_q    <= 1'b0;
      auto_q        <= AUTO_START;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      ts_q          <= ts_d;
      id_ok_q       <= id_ok_d;
      timeout_err_q <= timeout_err_d;
      tmo_done_q    <= tmo_done_d;
      auto_q        <= 1'b0;
    end
  end

  assign avm_read    = w_req;
  assign avm_address = (state_q == S_REQ_TS);
  assign busy        = w_busy;
  assign done        = (state_q == S_FIN) || tmo_done_q;
  assign id_ok       = id_ok_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule
`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sysid_boot_checker                                                    |
// | Randomised sysid slave plus a transaction-level model of each check.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sysid_boot_checker;

  localparam int          T      = 10;
  localparam logic [31:0] EXP_TS = 32'd1400042862;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        avm_address, avm_read, busy, done, id_ok, timeout_err;
  logic        waitreq = 1'b0, rdv = 1'b0;
  logic [31:0] rdata = '0, id_value, ts_value;

  always #5 clk = ~clk;

  sysid_boot_checker #(
    .EXPECTED_ID(32'd0), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
  ) dut (
    .clock(clk), .reset(rst), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(waitreq),
    .avm_readdata(rdata), .avm_readdatavalid(rdv),
    .busy(busy), .done(done), .id_ok(id_ok), .id_value(id_value),
    .ts_value(ts_value), .timeout_err(timeout_err)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Per-address slave behaviour for the next check
  int          cfg_stall[2], cfg_lat[2];
  bit          cfg_never[2];
  logic [31:0] cfg_data[2];
  bit          spur_en = 1'b0;

  bit          in_req = 1'b0;
  logic        cur_addr = 1'b0;
  int          stall_left = 0, resp_cnt = 0, n_done = 0;
  logic [31:0] resp_data = '0;

  always @(negedge clk) begin
    rdv   = 1'b0;
    rdata = $urandom;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        rdv   = 1'b1;
        rdata = resp_data;
      end
    end
    if (in_req) begin
      check("read_held", 32'(avm_read), 32'd1);
      check("addr_stable", 32'(avm_address), 32'(cur_addr));
    end
    if (!avm_read) begin
      in_req  = 1'b0;
      waitreq = 1'b0;
    end else begin
      if (!in_req) begin
        in_req     = 1'b1;
        cur_addr   = avm_address;
        stall_left = cfg_stall[cur_addr];
      end
      if (stall_left > 0) begin
        stall_left--;
        waitreq = 1'b1;
        if (spur_en && !rdv) rdv = ($urandom_range(0, 1) == 1);
      end else begin
        waitreq = 1'b0;
        in_req  = 1'b0;
        if (!cfg_never[cur_addr]) begin
          if (cfg_lat[cur_addr] == 0) begin
            rdv   = 1'b1;
            rdata = cfg_data[cur_addr];
          end else begin
            resp_cnt  = cfg_lat[cur_addr];
            resp_data = cfg_data[cur_addr];
          end
        end
      end
    end
    if (spur_en && !busy && !rdv && resp_cnt == 0) rdv = ($urandom_range(0, 3) == 0);
    if (done) n_done++;
  end

  // Expected outcome of the next check, from the slave configuration
  int          exp_lat;
  bit          exp_tmo, exp_ok;
  logic [31:0] m_id = '0, m_ts = '0;

  task automatic predict();
    int t0, t1, c1;
    bit got0, got1;
    t0   = cfg_never[0] ? 1000 : cfg_stall[0] + cfg_lat[0];
    t1   = cfg_never[1] ? 1000 : cfg_stall[1] + cfg_lat[1];
    got0 = (t0 <= T);
    got1 = got0 && (t1 <= T);
    c1   = 2 + cfg_stall[0] + cfg_lat[0];
    if (!got0)      exp_lat = T + 2;
    else if (!got1) exp_lat = c1 + T + 1;
    else            exp_lat = c1 + cfg_stall[1] + 1 + cfg_lat[1];
    exp_tmo = !got1;
    if (got0) m_id = cfg_data[0];
    if (got1) m_ts = cfg_data[1];
    exp_ok = got1 && (m_id == 32'd0) && (m_ts == EXP_TS);
  endtask

  task automatic set_cfg(input int s0, input int l0, input bit nv0, input logic [31:0] d0,
                         input int s1, input int l1, input bit nv1, input logic [31:0] d1);
    cfg_stall[0] = s0; cfg_lat[0] = l0; cfg_never[0] = nv0; cfg_data[0] = d0;
    cfg_stall[1] = s1; cfg_lat[1] = l1; cfg_never[1] = nv1; cfg_data[1] = d1;
  endtask

  task automatic check_reset_outputs();
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_id_ok", 32'(id_ok), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_id_value", id_value, 32'd0);
    check("rst_ts_value", ts_value, 32'd0);
  endtask

  // Called at the negedge of the launch cycle; mode 1 = random start, 2 = start held
  task automatic await_done(input int mode);
    int n, n0;
    n0 = n_done;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
      case (mode)
        1:       start = ($urandom_range(0, 1) == 1);
        2:       start = 1'b1;
        default: start = 1'b0;
      endcase
    end while (!done && n < 200);
    check("latency", 32'(n), 32'(exp_lat));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("read_after", 32'(avm_read), 32'd0);
    check("id_ok", 32'(id_ok), 32'(exp_ok));
    check("timeout_err", 32'(timeout_err), 32'(exp_tmo));
    check("id_value", id_value, m_id);
    check("ts_value", ts_value, m_ts);
    repeat (16) @(negedge clk);
    check("done_count", 32'(n_done - n0), 32'd1);
  endtask

  task automatic run(input int mode);
    predict();
    @(negedge clk);
    start = 1'b1;
    await_done(mode);
  endtask

  initial begin
    set_cfg(0, 1, 0, 32'd0, 0, 1, 0, EXP_TS);
    repeat (3) @(negedge clk);
    check_reset_outputs();
    predict();
    rst = 1'b0;
    await_done(0);

    set_cfg(0, 1, 0, 32'd0, 0, 1, 0, EXP_TS + 32'd1);  run(0);
    set_cfg(0, 1, 0, 32'd0, 7, 1, 0, EXP_TS);          run(0);
    set_cfg(0, 1, 1, 32'd0, 0, 1, 0, EXP_TS);          run(0);
    set_cfg(0, 1, 0, 32'd0, 0, 1, 0, EXP_TS);          run(2);

    // Reset while REQ_ID is accepted; its reply lands in the first post-reset IDLE cycle
    set_cfg(0, 2, 0, 32'hDEAD_BEEF, 0, 1, 0, EXP_TS);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    cfg_never[0] = 1'b1;
    m_id = '0;
    m_ts = '0;
    predict();
    @(negedge clk);
    rst = 1'b0;
    await_done(0);

    set_cfg(0, 0, 0, 32'd0, 0, 0, 0, EXP_TS);          run(0);
    set_cfg(3, 7, 0, 32'd0, 2, 8, 0, EXP_TS);          run(0);
    set_cfg(0, 1, 0, 32'h0000_1111, 2, 9, 0, EXP_TS);  run(0);

    spur_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 2; i++) begin
        cfg_stall[i] = $urandom_range(0, 4);
        cfg_lat[i]   = $urandom_range(0, 9);
        cfg_never[i] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) cfg_data[i] = $urandom;
        else                           cfg_data[i] = (i == 0) ? 32'd0 : EXP_TS;
      end
      run(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
